// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning front end.
// Button index constants are also used by the digit-entry stage.
package btn_pkg;

  localparam int unsigned NUM_BTN = 5;

  // Fixed bit mapping of the button bus
  localparam int unsigned BTN_LEFT  = 4;
  localparam int unsigned BTN_INC   = 3;
  localparam int unsigned BTN_RIGHT = 2;
  localparam int unsigned BTN_DEC   = 1;
  localparam int unsigned BTN_C     = 0;

  // Per-button pulse FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-FF synchroniser, debouncer and press/repeat pulse FSM.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   btn_i       - raw asynchronous button level
//   rpt_en_i    - enable auto-repeat pulses while held (static strap)
//   ok_o        - registered one-cycle press / repeat pulse
//   lvl_o       - registered debounced level
module btn_chan
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic rpt_en_i,
  output logic ok_o,
  output logic lvl_o
);

  localparam int unsigned DEB_W    = cnt_w(DEB_CYCLES);
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HOLD_W   = cnt_w(HOLD_MAX);

  localparam logic [DEB_W-1:0]  DEB_TC   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_TC = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_TC  = HOLD_W'(REPEAT_RATE - 1);

  logic [1:0]        sync_q;
  logic              s_c;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic              stable_q, stable_d;
  logic              accept_c;
  logic              fall_c;
  logic              rise_c;
  logic              lvl_q;
  logic              ok_q, ok_d;
  btn_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign s_c = sync_q[1];

  // Debouncer: a level change is accepted only after DEB_CYCLES unbroken mismatching cycles
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept_c = 1'b0;
    if (s_c == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_TC) begin
      accept_c = 1'b1;
      stable_d = s_c;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Release is taken at the cycle the debouncer accepts it, so a repeat
  // terminal count landing on that same cycle is suppressed.
  assign fall_c = accept_c & ~s_c;
  // Press is seen one cycle after acceptance, aligned with the level output.
  assign rise_c = stable_q & ~lvl_q;

  // Pulse FSM next-state and output logic
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ok_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        hold_d = '0;
        if (rise_c) begin
          ok_d = 1'b1;
          if (rpt_en_i) begin
            state_d = DELAY;
          end
        end
      end
      DELAY: begin
        if (fall_c || !stable_q) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == DELAY_TC) begin
          ok_d    = 1'b1;
          hold_d  = '0;
          state_d = REPEAT;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      REPEAT: begin
        if (fall_c || !stable_q) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == RATE_TC) begin
          ok_d   = 1'b1;
          hold_d = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // FSM state, hold counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ok_q    <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ok_q    <= ok_d;
      lvl_q   <= stable_q;
    end
  end

  assign ok_o  = ok_q;
  assign lvl_o = lvl_q;

endmodule

// File: rtl/btn_pulse.sv
// Button conditioning front end for the digit-entry stage. Five independent
// channels turn raw buttons into debounced levels and press/repeat pulses.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   BTN        - raw active-high buttons [4]=left [3]=inc [2]=right [1]=dec [0]=centre
//   BTN_OK     - registered one-cycle press / auto-repeat pulses
//   BTN_LVL    - registered debounced button levels
module btn_pulse
  import btn_pkg::*;
#(
  parameter int unsigned          DEB_CYCLES   = 1_000_000,
  parameter int unsigned          REPEAT_DELAY = 50_000_000,
  parameter int unsigned          REPEAT_RATE  = 10_000_000,
  parameter logic [NUM_BTN-1:0]   REPEAT_EN    = 5'b01010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] BTN,
  output logic [NUM_BTN-1:0] BTN_OK,
  output logic [NUM_BTN-1:0] BTN_LVL
);

  // One fully independent channel per button; no cross-button priority
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_chan #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (BTN[i]),
      .rpt_en_i(REPEAT_EN[i]),
      .ok_o    (BTN_OK[i]),
      .lvl_o   (BTN_LVL[i])
    );
  end

endmodule

// File: tb/tb_btn_pulse.sv
module tb_btn_pulse;
  import btn_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn   = 5'b00000;
  logic [4:0] btn_ok;
  logic [4:0] btn_lvl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_pulse #(
    .DEB_CYCLES  (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (8),
    .REPEAT_EN   (5'b01010)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .BTN    (btn),
    .BTN_OK (btn_ok),
    .BTN_LVL(btn_lvl)
  );

  task automatic chk(input string tag, input int e, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn   = 5'b00000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Glitch-then-bounce pattern for button 1, indexed by edge
  function automatic logic pat3(input int e);
    if (e <= 2) return 1'b1;
    if (e <= 5) return 1'b0;
    if (e == 6 || e == 8) return 1'b1;
    if (e == 7 || e == 9) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    // Reset state
    do_reset();
    chk("rst_ok", 0, btn_ok, 5'b00000);
    chk("rst_lvl", 0, btn_lvl, 5'b00000);

    // Clean press on left, no repeat, then release
    btn = 5'b10000;
    for (int e = 0; e < 100; e++) begin
      tick();
      chk("s1_ok", e, btn_ok, (e == 6) ? 5'b10000 : 5'b00000);
      chk("s1_lvl", e, btn_lvl, (e >= 6) ? 5'b10000 : 5'b00000);
    end
    btn = 5'b00000;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk("s1_rel_ok", e, btn_ok, 5'b00000);
      chk("s1_rel_lvl", e, btn_lvl, (e < 6) ? 5'b10000 : 5'b00000);
    end

    // Auto-repeat on increment, released at edge 45
    do_reset();
    btn = 5'b01000;
    for (int e = 0; e <= 70; e++) begin
      tick();
      chk("s2_ok", e, btn_ok, (e == 6 || e == 26 || e == 34 || e == 42) ? 5'b01000 : 5'b00000);
      chk("s2_lvl", e, btn_lvl, (e >= 6 && e < 51) ? 5'b01000 : 5'b00000);
      if (e == 44) btn = 5'b00000;
    end

    // Short glitch then bounce on decrement, settling high from edge 10
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      btn = {3'b000, pat3(e), 1'b0};
      tick();
      chk("s3_ok", e, btn_ok, (e == 16) ? 5'b00010 : 5'b00000);
      chk("s3_lvl", e, btn_lvl, (e >= 16) ? 5'b00010 : 5'b00000);
    end
    btn = 5'b00000;

    // Simultaneous press of left and right
    do_reset();
    btn = 5'b10100;
    for (int e = 0; e <= 12; e++) begin
      tick();
      chk("s4_ok", e, btn_ok, (e == 6) ? 5'b10100 : 5'b00000);
      chk("s4_lvl", e, btn_lvl, (e >= 6) ? 5'b10100 : 5'b00000);
    end

    // Reset asserted mid-hold, released with the button still held
    do_reset();
    btn = 5'b01000;
    for (int e = 0; e <= 30; e++) begin
      tick();
      chk("s5_ok", e, btn_ok, (e == 6 || e == 26) ? 5'b01000 : 5'b00000);
      chk("s5_lvl", e, btn_lvl, (e >= 6) ? 5'b01000 : 5'b00000);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_ok", 30, btn_ok, 5'b00000);
    chk("s5_rst_lvl", 30, btn_lvl, 5'b00000);
    for (int e = 31; e <= 34; e++) begin
      tick();
      chk("s5_inrst_ok", e, btn_ok, 5'b00000);
      chk("s5_inrst_lvl", e, btn_lvl, 5'b00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 35; e <= 70; e++) begin
      tick();
      chk("s5_post_ok", e, btn_ok, (e == 41 || e == 61 || e == 69) ? 5'b01000 : 5'b00000);
      chk("s5_post_lvl", e, btn_lvl, (e >= 41) ? 5'b01000 : 5'b00000);
    end
    btn = 5'b00000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
